// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the three buses that meet at the unified-memory arbiter:
//   the core memory port, the program loader/debug port, and the
//   single-ported memory itself.
//
//   Modports:
//     slave  - the arbiter: takes requests and mem_rdata, and drives acks,
//              rdata, stall and the memory strobe/address/data.
//     master - the environment: the core, the loader and the memory.
//
//   Parameters: AW address width, DW data width.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
) ();

   // core port
   logic          core_req;
   logic          core_we;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata;
   logic [DW-1:0] core_rdata;
   logic          core_ack;
   logic          core_stall;

   // loader / debug port
   logic          ldr_req;
   logic          ldr_we;
   logic          ldr_lock;
   logic [AW-1:0] ldr_addr;
   logic [DW-1:0] ldr_wdata;
   logic [DW-1:0] ldr_rdata;
   logic          ldr_ack;

   // memory port
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  core_req, core_we, core_addr, core_wdata,
      input  ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata,
      input  mem_rdata,
      output core_rdata, core_ack, core_stall,
      output ldr_rdata, ldr_ack,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata,
      output ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata,
      output mem_rdata,
      input  core_rdata, core_ack, core_stall,
      input  ldr_rdata, ldr_ack,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single-ported instruction/data memory between the core's
//   memory port and the program loader/debug port. Each access runs the
//   fixed sequence IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP -> IDLE.
//   The core is held stalled until its access acknowledges.
//
//   Parameters:
//     AW, DW     address / data width (passed through, no decoding)
//     MEM_LAT    cycles from the mem_en cycle to valid mem_rdata (>= 1)
//     MAX_GRANT  consecutive loader grants allowed while the core waits (>= 1)
//
//   Ports:
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    slave side of mem_port_arbiter_if (core, loader, memory buses)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MEM_LAT   = 1,
   parameter int MAX_GRANT = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   mem_port_arbiter_if.slave   bus
);

   localparam int SW = $clog2(MAX_GRANT + 1);
   localparam int CW = $clog2(MEM_LAT + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_GRANT);
   localparam logic [CW-1:0] LAT_LOAD   = CW'(MEM_LAT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   typedef enum logic {
      OWN_CORE,
      OWN_LDR
   } owner_t;

   state_t        state;
   owner_t        owner;
   logic [SW-1:0] streak;
   logic [CW-1:0] wait_cnt;
   logic          we_q;

   logic          mem_en_q;
   logic          mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q;
   logic [DW-1:0] core_rdata_q;
   logic [DW-1:0] ldr_rdata_q;
   logic          core_ack_q;
   logic          ldr_ack_q;

   // Grant decision, only meaningful in IDLE. The loader wins contention
   // while it is locked or has not yet used up its streak; the core is
   // never granted while the loader holds the lock.
   logic ldr_grant;
   logic core_grant;

   assign ldr_grant  = bus.ldr_req &
                       (~bus.core_req | bus.ldr_lock | (streak < STREAK_MAX));
   assign core_grant = bus.core_req & ~bus.ldr_lock & ~ldr_grant;

   // The stall must fall in the ack cycle itself, so it is combinational.
   assign bus.core_stall = bus.core_req & ~core_ack_q;

   assign bus.core_ack   = core_ack_q;
   assign bus.ldr_ack    = ldr_ack_q;
   assign bus.core_rdata = core_rdata_q;
   assign bus.ldr_rdata  = ldr_rdata_q;
   assign bus.mem_en     = mem_en_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;

   // NOTE: all state lives in this one clocked block and uses non-blocking
   // assignments, so every register sees pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         owner        <= OWN_CORE;
         streak       <= '0;
         wait_cnt     <= '0;
         we_q         <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         core_rdata_q <= '0;
         ldr_rdata_q  <= '0;
         core_ack_q   <= 1'b0;
         ldr_ack_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // Streak counts loader grants that made a waiting core wait.
               if (!bus.core_req || core_grant) begin
                  streak <= '0;
               end else if (ldr_grant && streak != STREAK_MAX) begin
                  streak <= streak + SW'(1);
               end

               if (ldr_grant) begin
                  owner       <= OWN_LDR;
                  we_q        <= bus.ldr_we;
                  mem_addr_q  <= bus.ldr_addr;
                  mem_wdata_q <= bus.ldr_wdata;
                  mem_we_q    <= bus.ldr_we;
                  mem_en_q    <= 1'b1;
                  state       <= S_ISSUE;
               end else if (core_grant) begin
                  owner       <= OWN_CORE;
                  we_q        <= bus.core_we;
                  mem_addr_q  <= bus.core_addr;
                  mem_wdata_q <= bus.core_wdata;
                  mem_we_q    <= bus.core_we;
                  mem_en_q    <= 1'b1;
                  state       <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               // Address/data registers keep the latched values after the strobe.
               mem_en_q <= 1'b0;
               mem_we_q <= 1'b0;
               wait_cnt <= LAT_LOAD;
               state    <= S_WAIT;
            end

            S_WAIT: begin
               wait_cnt <= wait_cnt - CW'(1);
               if (wait_cnt == CW'(1)) begin
                  if (!we_q) begin
                     if (owner == OWN_LDR) ldr_rdata_q  <= bus.mem_rdata;
                     else                  core_rdata_q <= bus.mem_rdata;
                  end
                  if (owner == OWN_LDR) ldr_ack_q  <= 1'b1;
                  else                  core_ack_q <= 1'b1;
                  state <= S_RESP;
               end
            end

            S_RESP: begin
               core_ack_q <= 1'b0;
               ldr_ack_q  <= 1'b0;
               state      <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. dut1 runs MEM_LAT=1, MAX_GRANT=2;
//   dut3 runs MEM_LAT=3 with the default MAX_GRANT. Each has a small memory
//   model that presents valid read data only in the cycle MEM_LAT after
//   mem_en, and a recognisable poison word at all other times.
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   on the falling edge. "Cycle n" is the n-th clock period after a grant.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic clk;
   logic rst_n;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter_if #(.AW(32), .DW(32)) bus1 ();
   mem_port_arbiter_if #(.AW(32), .DW(32)) bus3 ();

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_GRANT(2)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [31:0] POISON = 32'hBADBAD00;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h40) return 32'hDEADBEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   // Memory models: data valid only MEM_LAT cycles after the mem_en cycle.
   logic [1:0] lat1;
   logic [2:0] lat3;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)           lat1 <= 2'd0;
      else if (bus1.mem_en) lat1 <= 2'd1;
      else if (lat1 != 0)   lat1 <= lat1 - 2'd1;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)           lat3 <= 3'd0;
      else if (bus3.mem_en) lat3 <= 3'd3;
      else if (lat3 != 0)   lat3 <= lat3 - 3'd1;
   end

   assign bus1.mem_rdata = (lat1 == 2'd1) ? mem_word(bus1.mem_addr) : POISON;
   assign bus3.mem_rdata = (lat3 == 3'd1) ? mem_word(bus3.mem_addr) : POISON;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // contention bookkeeping
   logic [31:0] exp_order [6] = '{32'h20, 32'h20, 32'h80, 32'h20, 32'h20, 32'h80};
   int acc;
   int ack0;
   int ack1;
   int nack;
   int stall_low;
   int ldr_issues;
   int other_issues;

   initial begin
      rst_n = 1'b0;
      bus1.core_req = 0; bus1.core_we = 0; bus1.core_addr = 0; bus1.core_wdata = 0;
      bus1.ldr_req  = 0; bus1.ldr_we  = 0; bus1.ldr_lock  = 0;
      bus1.ldr_addr = 0; bus1.ldr_wdata = 0;
      bus3.core_req = 0; bus3.core_we = 0; bus3.core_addr = 0; bus3.core_wdata = 0;
      bus3.ldr_req  = 0; bus3.ldr_we  = 0; bus3.ldr_lock  = 0;
      bus3.ldr_addr = 0; bus3.ldr_wdata = 0;

      // ---------------- reset values
      #2;
      check("rst_mem_en",     bus1.mem_en,     0);
      check("rst_mem_we",     bus1.mem_we,     0);
      check("rst_mem_addr",   bus1.mem_addr,   0);
      check("rst_mem_wdata",  bus1.mem_wdata,  0);
      check("rst_core_ack",   bus1.core_ack,   0);
      check("rst_ldr_ack",    bus1.ldr_ack,    0);
      check("rst_core_rdata", bus1.core_rdata, 0);
      check("rst_ldr_rdata",  bus1.ldr_rdata,  0);
      check("rst_core_stall", bus1.core_stall, 0);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      // ---------------- core read, MEM_LAT=1
      bus1.core_req = 1; bus1.core_we = 0; bus1.core_addr = 32'h40;
      sample();                                   // cycle 0
      check("crd_c0_stall", bus1.core_stall, 1);
      check("crd_c0_en",    bus1.mem_en,     0);
      next_cycle(); sample();                     // cycle 1
      check("crd_c1_en",    bus1.mem_en,     1);
      check("crd_c1_we",    bus1.mem_we,     0);
      check("crd_c1_addr",  bus1.mem_addr,   32'h40);
      check("crd_c1_stall", bus1.core_stall, 1);
      next_cycle(); sample();                     // cycle 2
      check("crd_c2_en",    bus1.mem_en,     0);
      check("crd_c2_ack",   bus1.core_ack,   0);
      check("crd_c2_stall", bus1.core_stall, 1);
      next_cycle(); sample();                     // cycle 3
      check("crd_c3_ack",   bus1.core_ack,   1);
      check("crd_c3_rdata", bus1.core_rdata, 32'hDEADBEEF);
      check("crd_c3_stall", bus1.core_stall, 0);
      next_cycle();
      bus1.core_req = 0;
      sample();                                   // cycle 4, idle
      check("crd_c4_ack",   bus1.core_ack,   0);
      next_cycle();

      // ---------------- loader write
      bus1.ldr_req = 1; bus1.ldr_we = 1; bus1.ldr_addr = 32'h10; bus1.ldr_wdata = 32'h12345678;
      next_cycle(); sample();                     // cycle 1
      check("lwr_c1_en",    bus1.mem_en,    1);
      check("lwr_c1_we",    bus1.mem_we,    1);
      check("lwr_c1_addr",  bus1.mem_addr,  32'h10);
      check("lwr_c1_wdata", bus1.mem_wdata, 32'h12345678);
      next_cycle(); sample();                     // cycle 2
      check("lwr_c2_we",    bus1.mem_we,    0);
      check("lwr_c2_ack",   bus1.ldr_ack,   0);
      next_cycle(); sample();                     // cycle 3
      check("lwr_c3_ack",   bus1.ldr_ack,   1);
      check("lwr_c3_cack",  bus1.core_ack,  0);
      check("lwr_c3_rdata", bus1.ldr_rdata, 0);
      check("lwr_c3_crd",   bus1.core_rdata, 32'hDEADBEEF);
      next_cycle();
      bus1.ldr_req = 0; bus1.ldr_we = 0;
      next_cycle();

      // ---------------- contention, MAX_GRANT=2
      bus1.core_req = 1; bus1.core_we = 0; bus1.core_addr = 32'h80;
      bus1.ldr_req  = 1; bus1.ldr_we  = 0; bus1.ldr_addr  = 32'h20;
      acc = 0; ack0 = -1; ack1 = -1; nack = 0;
      for (int c = 0; c < 24; c++) begin
         sample();
         if (bus1.mem_en) begin
            if (acc < 6) check("cont_order", bus1.mem_addr, exp_order[acc]);
            acc++;
         end
         if (bus1.core_ack) begin
            if (nack == 0) ack0 = c;
            else if (nack == 1) ack1 = c;
            nack++;
            check("cont_crdata", bus1.core_rdata, 32'h0080FF7F);
         end
         next_cycle();
      end
      bus1.core_req = 0; bus1.ldr_req = 0;
      check("cont_accesses", acc,  6);
      check("cont_nack",     nack, 2);
      check("cont_ack0",     ack0, 11);
      check("cont_ack1",     ack1, 23);
      check("cont_ldr_rd",   bus1.ldr_rdata, 32'h0020FFDF);
      next_cycle();

      // ---------------- lock: 10 loader accesses, core starved
      bus1.ldr_lock = 1;
      bus1.core_req = 1; bus1.core_addr = 32'h84;
      bus1.ldr_req  = 1; bus1.ldr_addr  = 32'h24;
      nack = 0; stall_low = 0; ldr_issues = 0; other_issues = 0;
      for (int c = 0; c < 40; c++) begin
         sample();
         if (bus1.core_ack)    nack++;
         if (!bus1.core_stall) stall_low++;
         if (bus1.mem_en) begin
            if (bus1.mem_addr == 32'h24) ldr_issues++;
            else                         other_issues++;
         end
         next_cycle();
      end
      check("lock_core_acks",  nack,         0);
      check("lock_stall_low",  stall_low,    0);
      check("lock_ldr_issues", ldr_issues,   10);
      check("lock_other",      other_issues, 0);
      bus1.ldr_lock = 0; bus1.ldr_req = 0;       // cycle 0 of the core grant
      next_cycle(); sample();                     // cycle 1
      check("unlock_c1_en",   bus1.mem_en,   1);
      check("unlock_c1_addr", bus1.mem_addr, 32'h84);
      next_cycle(); next_cycle(); sample();       // cycle 3
      check("unlock_c3_ack",  bus1.core_ack,   1);
      check("unlock_c3_rd",   bus1.core_rdata, 32'h0084FF7B);
      next_cycle();
      bus1.core_req = 0;
      next_cycle();

      // ---------------- MEM_LAT=3 read
      bus3.core_req = 1; bus3.core_we = 0; bus3.core_addr = 32'h40;
      next_cycle(); sample();                     // cycle 1
      check("lat3_c1_en",  bus3.mem_en, 1);
      next_cycle(); sample();                     // cycle 2
      next_cycle(); sample();                     // cycle 3
      check("lat3_c3_ack", bus3.core_ack, 0);
      next_cycle(); sample();                     // cycle 4
      check("lat3_c4_ack", bus3.core_ack, 0);
      check("lat3_c4_rd",  bus3.core_rdata, 0);
      next_cycle(); sample();                     // cycle 5
      check("lat3_c5_ack", bus3.core_ack, 1);
      check("lat3_c5_rd",  bus3.core_rdata, 32'hDEADBEEF);
      check("lat3_c5_stall", bus3.core_stall, 0);
      next_cycle();
      bus3.core_req = 0;
      sample();                                   // cycle 6, idle
      check("lat3_c6_ack", bus3.core_ack, 0);
      next_cycle();

      // ---------------- reset mid-WAIT
      bus1.core_req = 1; bus1.core_we = 0; bus1.core_addr = 32'h44;
      next_cycle();                               // cycle 1 (issue)
      next_cycle();                               // cycle 2 (wait)
      rst_n = 1'b0;
      #1;
      check("rstw_en",    bus1.mem_en,     0);
      check("rstw_ack",   bus1.core_ack,   0);
      check("rstw_addr",  bus1.mem_addr,   0);
      check("rstw_crd",   bus1.core_rdata, 0);
      check("rstw_lrd",   bus1.ldr_rdata,  0);
      check("rstw_crd3",  bus3.core_rdata, 0);
      nack = 0;
      for (int c = 0; c < 3; c++) begin
         sample();
         if (bus1.core_ack || bus1.mem_en) nack++;
         next_cycle();
      end
      check("rstw_quiet", nack, 0);
      rst_n = 1'b1;                               // re-issue: cycle 0
      sample();
      check("reiss_c0_stall", bus1.core_stall, 1);
      next_cycle(); sample();                     // cycle 1
      check("reiss_c1_en",   bus1.mem_en,   1);
      check("reiss_c1_addr", bus1.mem_addr, 32'h44);
      next_cycle(); next_cycle(); sample();       // cycle 3
      check("reiss_c3_ack",  bus1.core_ack,   1);
      check("reiss_c3_rd",   bus1.core_rdata, 32'h0044FFBB);
      next_cycle();
      bus1.core_req = 0;
      next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-ported unified instruction/data memory of the multicycle core. It shares the memory between the core's memory port and the program loader/debug port, runs the fixed issue/wait/response sequence, and holds the core stalled until its access completes. The core controller gates its PC and IR write enables with `core_stall`.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `MEM_LAT`, default 1: cycles from the `mem_en` cycle to valid `mem_rdata`. Minimum 1.
- `MAX_GRANT`, default 8: consecutive loader grants allowed while the core waits, before the core is forced in. Minimum 1.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `core_req`, `core_we` in 1, 1: core access request and write flag.
- `core_addr`, `core_wdata` in AW, DW: core address and write data.
- `core_rdata` out DW: core read data, registered.
- `core_ack` out 1: one-cycle completion pulse for a core access.
- `core_stall` out 1: `core_req & ~core_ack` (combinational).
- `ldr_req`, `ldr_we`, `ldr_lock` in 1, 1, 1: loader request, write flag, and exclusive mode (core never granted).
- `ldr_addr`, `ldr_wdata` in AW, DW: loader address and write data.
- `ldr_rdata` out DW: loader read data, registered.
- `ldr_ack` out 1: one-cycle completion pulse for a loader access.
- `mem_en`, `mem_we` out 1, 1: memory strobe and write enable.
- `mem_addr`, `mem_wdata` out AW, DW: memory address and write data.
- `mem_rdata` in DW: memory read data.

## Operation
- **States:** IDLE → ISSUE → WAIT → RESP → IDLE. The owner register holds CORE or LDR.
- **IDLE:** sample the requests.
  - Both `ldr_req` and `core_req` high: grant LDR if `ldr_lock` is high or `streak < MAX_GRANT`; otherwise grant CORE.
  - Only one requester high: grant it, except that `core_req` with `ldr_lock` high is not granted.
  - On a grant, latch owner, we, addr and wdata, then go to ISSUE. With no grant, stay in IDLE.
- **streak counter:**
  - Increments on each LDR grant while `core_req` is high, saturating at `MAX_GRANT`.
  - Clears on each CORE grant.
  - Clears in IDLE when `core_req` is low.
- **ISSUE (1 cycle):** `mem_en=1`; `mem_we` = latched we; `mem_addr`/`mem_wdata` = latched values.
- **WAIT (MEM_LAT cycles):** a down-counter loads MEM_LAT. On the last WAIT cycle, capture `mem_rdata` into the owner's rdata register, for reads only. Writes leave rdata unchanged.
- **RESP (1 cycle):** assert the owner's ack, then go to IDLE.
- Outside ISSUE: `mem_en=0` and `mem_we=0`; `mem_addr`/`mem_wdata` hold the last latched values.
- Each rdata register holds its value until the next read by its own port.
- **Requester protocol:**
  - Hold req, we, addr and wdata stable until ack.
  - The IDLE cycle after RESP samples req again, so a req still high there is treated as a new request.
  - Dropping req mid-access is a protocol violation. The access still completes and ack still pulses.
- Address and data widths pass through unchanged; no decoding or range check.

## Timing
- Reset values: state IDLE; owner CORE; streak 0; wait counter 0; all acks 0; `mem_en`/`mem_we` 0; `mem_addr`, `mem_wdata`, `core_rdata`, `ldr_rdata` all 0.
- Access timeline, with the grant in IDLE at cycle 0:
  - Cycle 1: `mem_en`.
  - Cycles 2..1+MEM_LAT: WAIT; data captured at the end of cycle 1+MEM_LAT.
  - Cycle 2+MEM_LAT: ack, with rdata valid in the same cycle.
  - Cycle 3+MEM_LAT: IDLE.
- Reads and writes have identical timing.
- Peak throughput is one access per 3+MEM_LAT cycles (4 at the default).
- `core_stall` is high from `core_req` rising through the cycle before `core_ack`, and low in the ack cycle.
- `ldr_lock` is sampled only in IDLE; it does not abort a core access already in flight.
- Reset asserted mid-access:
  - Immediate return to IDLE; `mem_en` and ack drop asynchronously.
  - The in-flight access is lost with no ack; requesters re-issue after reset.

## Test plan
- **Core read, MEM_LAT=1:** `core_req` with addr 0x40, memory returning 0xDEADBEEF → `mem_en` in cycle 1, `core_ack` in cycle 3 with `core_rdata=0xDEADBEEF`, `core_stall` high in cycles 0–2.
- **Loader write:** addr 0x10, data 0x12345678 → `mem_en=mem_we=1` in cycle 1 with that addr/data; `ldr_ack` in cycle 3; `ldr_rdata` unchanged.
- **Contention, MAX_GRANT=2:** `core_req` and `ldr_req` held continuously → grant order LDR, LDR, CORE, LDR, LDR, CORE; `core_ack` every 12 cycles.
- **Lock:** `ldr_lock=1`, both requesting for 10 accesses → no `core_ack`, `core_stall` stays high. Drop lock and `ldr_req` → core granted at the next IDLE.
- **MEM_LAT=3 read:** ack in cycle 5, data captured at the end of cycle 4.
- **Reset mid-WAIT:** assert `rst_n=0` in cycle 2 of a core read → no ack, all outputs at reset values. After release, re-issue completes normally.
